// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM port arbiter and the sdram_controller
// wrappers: bus widths, the arbiter state encoding and the starvation-counter
// update rule.
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

    // SDRAM word address and data widths used on both sides of the arbiter
    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

    // Width of the write-starvation counter (limit may be anything 1..255)
    localparam int STARVE_W = 8;

    // Arbiter transaction states: one transaction is in flight at a time
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_WR = 3'd1,
        ISSUE_RD = 3'd2,
        WAIT_WR  = 3'd3,
        WAIT_RD  = 3'd4
    } arb_state_t;

    // Next value of the starvation counter.
    // A write grant always clears it. A read grant taken while a write is
    // waiting counts one more "skip" of the write, saturating at the limit.
    // An idle cycle with no write pending means nobody is starving, so the
    // count is cleared there as well.
    function automatic logic [STARVE_W-1:0] starve_update(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] limit,
        input logic                grant_rd,
        input logic                grant_wr,
        input logic                wr_valid,
        input logic                idle
    );
        logic [STARVE_W-1:0] result;
        result = cnt;
        if (grant_wr) begin
            result = '0;
        end else if (grant_rd && wr_valid) begin
            if (cnt < limit) begin
                result = cnt + 8'd1;
            end
        end else if (idle && !wr_valid) begin
            result = '0;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if
// Bundles every handshake and bus signal around the arbiter:
//   wr_req_*   : renderer pixel-store write request port
//   rd_req_*   : display framebuffer fetch read request port
//   rd_resp_*  : read response strobe and data back to the fetch logic
//   ctrl_*     : host interface of sdram_controller
// Modports:
//   slave  : the arbiter's view (takes requests, drives the controller)
//   master : the surrounding logic's view (requesters plus controller)
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W,
    parameter int DATA_W = SDRAM_DATA_W
) ();

    // Write request port
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;

    // Read request port and its response
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;

    // sdram_controller host interface
    logic [ADDR_W-1:0] ctrl_wr_addr;
    logic [DATA_W-1:0] ctrl_wr_data;
    logic              ctrl_wr_enable;
    logic [ADDR_W-1:0] ctrl_rd_addr;
    logic              ctrl_rd_enable;
    logic [DATA_W-1:0] ctrl_rd_data;
    logic              ctrl_rd_ready;
    logic              ctrl_busy;

    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_data,
        input  rd_req_valid, rd_req_addr,
        input  ctrl_rd_data, ctrl_rd_ready, ctrl_busy,
        output wr_req_ready, rd_req_ready,
        output rd_resp_valid, rd_resp_data,
        output ctrl_wr_addr, ctrl_wr_data, ctrl_wr_enable,
        output ctrl_rd_addr, ctrl_rd_enable
    );

    modport master (
        output wr_req_valid, wr_req_addr, wr_req_data,
        output rd_req_valid, rd_req_addr,
        output ctrl_rd_data, ctrl_rd_ready, ctrl_busy,
        input  wr_req_ready, rd_req_ready,
        input  rd_resp_valid, rd_resp_data,
        input  ctrl_wr_addr, ctrl_wr_data, ctrl_wr_enable,
        input  ctrl_rd_addr, ctrl_rd_enable
    );

endinterface

// File: rtl/sdram_arb_prio.sv
// ---------------------------------------------------------------------------
// sdram_arb_prio
// Grant selection between the read and write ports plus the write
// starvation counter. Reads win by default (scanout is latency critical);
// once WR_MAX_WAIT reads have been granted over a pending write, the write
// is forced through next.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_valid   : write request pending
//   rd_valid   : read request pending
//   accept     : the arbiter can take a request this cycle
//   idle       : the arbiter is in its idle state
//   grant_rd   : read request is accepted this cycle
//   grant_wr   : write request is accepted this cycle
// ---------------------------------------------------------------------------
module sdram_arb_prio
    import sdram_arb_pkg::*;
#(
    parameter int WR_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_valid,
    input  logic rd_valid,
    input  logic accept,
    input  logic idle,
    output logic grant_rd,
    output logic grant_wr
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(WR_MAX_WAIT);

    logic [STARVE_W-1:0] starve_cnt;
    logic                wr_forced;

    // Grant select: the read port wins unless a pending write has already
    // been passed over the maximum number of times. Both grants are gated by
    // accept, so at most one is ever high and neither is high when the
    // arbiter cannot take a request.
    always_comb begin
        wr_forced = wr_valid && (starve_cnt == STARVE_LIMIT);
        grant_rd  = accept && rd_valid && !wr_forced;
        grant_wr  = accept && wr_valid && !(rd_valid && !wr_forced);
    end

    // Starvation counter: advanced or cleared according to the grant
    // taken this cycle and whether a write is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_update(starve_cnt, STARVE_LIMIT, grant_rd,
                                        grant_wr, wr_valid, idle);
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
// Shares the single host interface of sdram_controller between the display
// framebuffer fetch (read port) and the renderer pixel store (write port).
// One transaction is in flight at a time: the request is latched into the
// ctrl_* registers, the enable is held until the controller reports busy,
// then the arbiter waits for the transaction to finish before going idle.
// Read data comes back on a one-cycle rd_resp_valid strobe.
// Ports:
//   clk   : system clock, shared with sdram_controller
//   rst_n : asynchronous active-low reset
//   bus   : request ports, read response and controller host interface
// ---------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int WR_MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_port_arbiter_if.slave  bus
);

    arb_state_t state;
    arb_state_t state_next;

    logic idle;
    logic accept;
    logic grant_rd;
    logic grant_wr;
    logic load_wr;
    logic load_rd;
    logic capture;

    // Requests are only taken in IDLE, out of reset, and once the controller
    // has dropped busy from the previous transaction.
    always_comb begin
        idle   = (state == IDLE);
        accept = idle && rst_n && !bus.ctrl_busy;
    end

    sdram_arb_prio #(
        .WR_MAX_WAIT (WR_MAX_WAIT)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (bus.wr_req_valid),
        .rd_valid (bus.rd_req_valid),
        .accept   (accept),
        .idle     (idle),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    // The readies are the grants themselves, so a request is accepted in the
    // very cycle it is granted.
    always_comb begin
        bus.rd_req_ready = grant_rd;
        bus.wr_req_ready = grant_wr;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes.
    // A read response that arrives before busy was seen still completes the
    // read, since the controller may finish a short access in one go.
    always_comb begin
        state_next = state;
        load_wr    = 1'b0;
        load_rd    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_next = ISSUE_WR;
                    load_wr    = 1'b1;
                end else if (grant_rd) begin
                    state_next = ISSUE_RD;
                    load_rd    = 1'b1;
                end
            end
            ISSUE_WR: begin
                if (bus.ctrl_busy) begin
                    state_next = WAIT_WR;
                end
            end
            ISSUE_RD: begin
                if (bus.ctrl_rd_ready) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end else if (bus.ctrl_busy) begin
                    state_next = WAIT_RD;
                end
            end
            WAIT_WR: begin
                if (!bus.ctrl_busy) begin
                    state_next = IDLE;
                end
            end
            WAIT_RD: begin
                if (bus.ctrl_rd_ready) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller-side registers and the read response.
    // The enables are registered decodes of the next state, so each is high
    // exactly while the FSM sits in the matching ISSUE state and they can
    // never be high together. Address and data only change on a load, which
    // keeps them stable through ISSUE and WAIT. rd_resp_valid follows the
    // capture strobe by one cycle and is therefore a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ctrl_wr_addr   <= '0;
            bus.ctrl_wr_data   <= '0;
            bus.ctrl_wr_enable <= 1'b0;
            bus.ctrl_rd_addr   <= '0;
            bus.ctrl_rd_enable <= 1'b0;
            bus.rd_resp_valid  <= 1'b0;
            bus.rd_resp_data   <= '0;
        end else begin
            bus.ctrl_wr_enable <= (state_next == ISSUE_WR);
            bus.ctrl_rd_enable <= (state_next == ISSUE_RD);
            bus.rd_resp_valid  <= capture;
            if (load_wr) begin
                bus.ctrl_wr_addr <= bus.wr_req_addr;
                bus.ctrl_wr_data <= bus.wr_req_data;
            end
            if (load_rd) begin
                bus.ctrl_rd_addr <= bus.rd_req_addr;
            end
            if (capture) begin
                bus.rd_resp_data <= bus.ctrl_rd_data;
            end
        end
    end

    // Structural properties of the arbiter outputs.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.ctrl_wr_enable && bus.ctrl_rd_enable));
            assert (!(bus.wr_req_ready && bus.rd_req_ready));
        end
    end

endmodule
